// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared types and lane-map helper for the ARM MEM stage
package arm_mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        BAD  = 2'b11
    } mem_size_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam int WAIT_CNT_W = 8;

    // Bit k of mask is byte offset k; reverse sends offset k to lane 3-k.
    function automatic logic [3:0] lane_map(input logic [3:0] mask, input bit reverse);
        return reverse ? {mask[0], mask[1], mask[2], mask[3]} : mask;
    endfunction

endpackage

// File: rtl/arm_mem_lane_align.sv
// rtl/arm_mem_lane_align.sv - store replicate/lane enables and load rotate/extend
module arm_mem_lane_align
    import arm_mem_pkg::*;
#(
    parameter bit LANE_REVERSE = 1'b1
) (
    input  mem_size_t   i_size,
    input  logic [1:0]  i_off,
    input  logic        i_signed,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_store_data,
    output logic [3:0]  o_lane_en,
    output logic [31:0] o_load_data
);

    logic [31:0] w_rot;
    logic [3:0]  w_off_mask;

    always_comb begin
        w_off_mask   = 4'b0000;
        o_store_data = i_store_data;
        case (i_size)
            BYTE: begin
                w_off_mask   = 4'b0001 << i_off;
                o_store_data = {4{i_store_data[7:0]}};
            end
            HALF: begin
                w_off_mask   = 4'b0011 << i_off;
                o_store_data = {2{i_store_data[15:0]}};
            end
            WORD:    w_off_mask = 4'b1111;
            default: w_off_mask = 4'b0000;
        endcase
        o_lane_en = lane_map(w_off_mask, LANE_REVERSE);
    end

    // ARM unaligned word loads return the word rotated right by the byte offset.
    always_comb begin
        w_rot = i_mem_rdata;
        case (i_off)
            2'd1:    w_rot = {i_mem_rdata[7:0],  i_mem_rdata[31:8]};
            2'd2:    w_rot = {i_mem_rdata[15:0], i_mem_rdata[31:16]};
            2'd3:    w_rot = {i_mem_rdata[23:0], i_mem_rdata[31:24]};
            default: w_rot = i_mem_rdata;
        endcase
    end

    always_comb begin
        o_load_data = w_rot;
        case (i_size)
            BYTE:    o_load_data = {{24{i_signed & w_rot[7]}}, w_rot[7:0]};
            HALF:    o_load_data = {{16{i_signed & w_rot[15]}}, w_rot[15:0]};
            default: o_load_data = w_rot;
        endcase
    end

endmodule

// File: rtl/arm_mem_access_unit.sv
// rtl/arm_mem_access_unit.sv - MEM stage with req/ready memory port, stall, timeout and fault
module arm_mem_access_unit
    import arm_mem_pkg::*;
#(
    parameter int MAX_WAIT     = 15,
    parameter bit LANE_REVERSE = 1'b1,
    parameter bit HALF_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXMEM_valid,
    input  logic [31:0] EXMEM_data_result,
    input  logic [31:0] EXMEM_rd_data,
    input  logic        EXMEM_rd_we,
    input  logic        EXMEM_rd_data_sel,
    input  logic [3:0]  EXMEM_des_reg_num,
    input  logic        EXMEM_is_load,
    input  logic        EXMEM_is_store,
    input  logic [1:0]  EXMEM_size,
    input  logic        EXMEM_signed,
    output logic        mem_req,
    input  logic        mem_ready,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_write_en,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_stall,
    output logic        MEMID_rd_we,
    output logic [3:0]  MEMID_rd_num,
    output logic        MEMWB_valid,
    output logic        MEMWB_fault,
    output logic [31:0] MEMWB_data_read_from_mem,
    output logic [31:0] MEMWB_rd_data,
    output logic        MEMWB_rd_we,
    output logic        MEMWB_rd_data_sel,
    output logic [3:0]  MEMWB_des_reg_num
);

    mem_state_t              r_state;
    mem_state_t              w_state_nxt;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic [WAIT_CNT_W-1:0]   w_wait_cnt_nxt;

    mem_size_t   w_size;
    logic [1:0]  w_off;
    logic        w_acc;
    logic        w_illegal;
    logic        w_req;
    logic        w_abort;
    logic        w_stall;
    logic        w_fault;
    logic [3:0]  w_lane_en;
    logic [31:0] w_load_data;

    assign w_size = mem_size_t'(EXMEM_size);
    assign w_off  = EXMEM_data_result[1:0];
    assign w_acc  = EXMEM_valid & (EXMEM_is_load | EXMEM_is_store);

    // Illegality only matters for real accesses; plain ALU ops never fault.
    assign w_illegal = w_acc & ((w_size == BAD)
                              | ((w_size == HALF) & (w_off[0] | ~HALF_EN))
                              | (EXMEM_is_load & EXMEM_is_store));

    assign w_req = w_acc & ~w_illegal;

    arm_mem_lane_align #(
        .LANE_REVERSE (LANE_REVERSE)
    ) u_lane_align (
        .i_size       (w_size),
        .i_off        (w_off),
        .i_signed     (EXMEM_signed),
        .i_store_data (EXMEM_rd_data),
        .i_mem_rdata  (mem_data_out),
        .o_store_data (mem_data_in),
        .o_lane_en    (w_lane_en),
        .o_load_data  (w_load_data)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_abort        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req && !mem_ready) begin
                    w_state_nxt    = WAIT;
                    w_wait_cnt_nxt = WAIT_CNT_W'(1);
                end
            end
            WAIT: begin
                if (!w_req || mem_ready) begin
                    w_state_nxt    = IDLE;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WAIT_CNT_W'(MAX_WAIT)) begin
                    w_abort        = 1'b1;
                    w_state_nxt    = IDLE;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    assign w_stall      = w_req & ~mem_ready & ~w_abort;
    assign w_fault      = w_illegal | w_abort;
    assign mem_req      = w_req;
    assign mem_stall    = w_stall;
    assign mem_addr     = EXMEM_data_result[31:2];
    assign mem_write_en = (w_req & EXMEM_is_store) ? w_lane_en : 4'b0000;
    assign MEMID_rd_we  = EXMEM_valid & EXMEM_rd_we;
    assign MEMID_rd_num = EXMEM_des_reg_num;

    // A stalled cycle pushes a bubble so writeback never sees a half-done access.
    always_ff @(posedge clk) begin
        if (rst) begin
            MEMWB_valid              <= 1'b0;
            MEMWB_fault              <= 1'b0;
            MEMWB_data_read_from_mem <= '0;
            MEMWB_rd_data            <= '0;
            MEMWB_rd_we              <= 1'b0;
            MEMWB_rd_data_sel        <= 1'b0;
            MEMWB_des_reg_num        <= '0;
        end else if (w_stall) begin
            MEMWB_valid <= 1'b0;
            MEMWB_fault <= 1'b0;
            MEMWB_rd_we <= 1'b0;
        end else begin
            MEMWB_valid              <= EXMEM_valid;
            MEMWB_fault              <= w_fault;
            MEMWB_data_read_from_mem <= w_load_data;
            MEMWB_rd_data            <= EXMEM_data_result;
            MEMWB_rd_we              <= EXMEM_rd_we & ~w_fault;
            MEMWB_rd_data_sel        <= EXMEM_rd_data_sel;
            MEMWB_des_reg_num        <= EXMEM_des_reg_num;
        end
    end

endmodule

// File: tb/tb_arm_mem_access_unit.sv
// tb/tb_arm_mem_access_unit.sv - directed vector bench for arm_mem_access_unit
module tb_arm_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        EXMEM_valid;
    logic [31:0] EXMEM_data_result;
    logic [31:0] EXMEM_rd_data;
    logic        EXMEM_rd_we;
    logic        EXMEM_rd_data_sel;
    logic [3:0]  EXMEM_des_reg_num;
    logic        EXMEM_is_load;
    logic        EXMEM_is_store;
    logic [1:0]  EXMEM_size;
    logic        EXMEM_signed;
    logic        mem_req;
    logic        mem_ready;
    logic [29:0] mem_addr;
    logic [3:0]  mem_write_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_stall;
    logic        MEMID_rd_we;
    logic [3:0]  MEMID_rd_num;
    logic        MEMWB_valid;
    logic        MEMWB_fault;
    logic [31:0] MEMWB_data_read_from_mem;
    logic [31:0] MEMWB_rd_data;
    logic        MEMWB_rd_we;
    logic        MEMWB_rd_data_sel;
    logic [3:0]  MEMWB_des_reg_num;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arm_mem_access_unit #(
        .MAX_WAIT     (4),
        .LANE_REVERSE (1'b1),
        .HALF_EN      (1'b1)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .EXMEM_valid              (EXMEM_valid),
        .EXMEM_data_result        (EXMEM_data_result),
        .EXMEM_rd_data            (EXMEM_rd_data),
        .EXMEM_rd_we              (EXMEM_rd_we),
        .EXMEM_rd_data_sel        (EXMEM_rd_data_sel),
        .EXMEM_des_reg_num        (EXMEM_des_reg_num),
        .EXMEM_is_load            (EXMEM_is_load),
        .EXMEM_is_store           (EXMEM_is_store),
        .EXMEM_size               (EXMEM_size),
        .EXMEM_signed             (EXMEM_signed),
        .mem_req                  (mem_req),
        .mem_ready                (mem_ready),
        .mem_addr                 (mem_addr),
        .mem_write_en             (mem_write_en),
        .mem_data_in              (mem_data_in),
        .mem_data_out             (mem_data_out),
        .mem_stall                (mem_stall),
        .MEMID_rd_we              (MEMID_rd_we),
        .MEMID_rd_num             (MEMID_rd_num),
        .MEMWB_valid              (MEMWB_valid),
        .MEMWB_fault              (MEMWB_fault),
        .MEMWB_data_read_from_mem (MEMWB_data_read_from_mem),
        .MEMWB_rd_data            (MEMWB_rd_data),
        .MEMWB_rd_we              (MEMWB_rd_we),
        .MEMWB_rd_data_sel        (MEMWB_rd_data_sel),
        .MEMWB_des_reg_num        (MEMWB_des_reg_num)
    );

    typedef struct {
        logic        v;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ld;
        logic        st;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] mdo;
        logic        rdy;
        logic        e_req;
        logic [3:0]  e_we;
        logic [31:0] e_din;
        logic        e_fault;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic v, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                                input logic [31:0] mdo, input logic rdy, input logic e_req,
                                input logic [3:0] e_we, input logic [31:0] e_din,
                                input logic e_fault, input logic [31:0] e_rdata);
        vec_t r;
        r.v = v; r.addr = addr; r.wdata = wdata; r.ld = ld; r.st = st; r.sz = sz; r.sg = sg;
        r.mdo = mdo; r.rdy = rdy; r.e_req = e_req; r.e_we = e_we; r.e_din = e_din;
        r.e_fault = e_fault; r.e_rdata = e_rdata;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic ld,
                         input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] mdo, input logic rdy);
        EXMEM_valid       = v;
        EXMEM_data_result = a;
        EXMEM_rd_data     = d;
        EXMEM_rd_we       = v;
        EXMEM_rd_data_sel = 1'b1;
        EXMEM_des_reg_num = 4'd5;
        EXMEM_is_load     = ld;
        EXMEM_is_store    = st;
        EXMEM_size        = sz;
        EXMEM_signed      = sg;
        mem_data_out      = mdo;
        mem_ready         = rdy;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        vecs[0]  = mk(1, 32'h100, 32'hDEADBEEF, 0, 1, 2'b10, 0, 32'h0,        1, 1, 4'hF, 32'hDEADBEEF, 0, 32'h0);
        vecs[1]  = mk(1, 32'h103, 32'h000000A5, 0, 1, 2'b00, 0, 32'h0,        1, 1, 4'h1, 32'hA5A5A5A5, 0, 32'h0);
        vecs[2]  = mk(1, 32'h100, 32'h00000012, 0, 1, 2'b00, 0, 32'h0,        1, 1, 4'h8, 32'h12121212, 0, 32'h0);
        vecs[3]  = mk(1, 32'h102, 32'h0000BEEF, 0, 1, 2'b01, 0, 32'h0,        1, 1, 4'h3, 32'hBEEFBEEF, 0, 32'h0);
        vecs[4]  = mk(1, 32'h100, 32'h00001234, 0, 1, 2'b01, 0, 32'h0,        1, 1, 4'hC, 32'h12341234, 0, 32'h0);
        vecs[5]  = mk(1, 32'h103, 32'h0,        1, 0, 2'b00, 1, 32'hA5000000, 1, 1, 4'h0, 32'h0,        0, 32'hFFFFFFA5);
        vecs[6]  = mk(1, 32'h103, 32'h0,        1, 0, 2'b00, 0, 32'hA5000000, 1, 1, 4'h0, 32'h0,        0, 32'h000000A5);
        vecs[7]  = mk(1, 32'h101, 32'h0,        1, 0, 2'b10, 0, 32'h11223344, 1, 1, 4'h0, 32'h0,        0, 32'h44112233);
        vecs[8]  = mk(1, 32'h102, 32'h0,        1, 0, 2'b01, 1, 32'h80010000, 1, 1, 4'h0, 32'h0,        0, 32'hFFFF8001);
        vecs[9]  = mk(1, 32'h100, 32'h0,        1, 0, 2'b01, 0, 32'h1234ABCD, 1, 1, 4'h0, 32'h0,        0, 32'h0000ABCD);
        vecs[10] = mk(1, 32'h101, 32'h0,        1, 0, 2'b01, 0, 32'h0,        1, 0, 4'h0, 32'h0,        1, 32'h0);
        vecs[11] = mk(1, 32'h100, 32'h0,        1, 0, 2'b11, 0, 32'h0,        1, 0, 4'h0, 32'h0,        1, 32'h0);
        vecs[12] = mk(1, 32'h100, 32'h0,        1, 1, 2'b10, 0, 32'h0,        1, 0, 4'h0, 32'h0,        1, 32'h0);
        vecs[13] = mk(1, 32'h2A4, 32'h0,        0, 0, 2'b10, 0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 32'h0);
        vecs[14] = mk(0, 32'h100, 32'h0,        1, 0, 2'b10, 0, 32'h0,        1, 0, 4'h0, 32'h0,        0, 32'h0);

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset MEMWB_valid", {31'b0, MEMWB_valid}, 32'h0);
        chk("reset MEMWB_fault", {31'b0, MEMWB_fault}, 32'h0);
        chk("reset MEMWB_rd_we", {31'b0, MEMWB_rd_we}, 32'h0);
        chk("reset MEMWB_rd_data", MEMWB_rd_data, 32'h0);
        chk("reset MEMWB_data_read", MEMWB_data_read_from_mem, 32'h0);
        chk("reset mem_req", {31'b0, mem_req}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v, vecs[i].addr, vecs[i].wdata, vecs[i].ld, vecs[i].st, vecs[i].sz,
                  vecs[i].sg, vecs[i].mdo, vecs[i].rdy);
            #1;
            chk($sformatf("v%0d mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d mem_write_en", i), {28'b0, mem_write_en}, {28'b0, vecs[i].e_we});
            chk($sformatf("v%0d mem_addr", i), {2'b0, mem_addr}, {2'b0, vecs[i].addr[31:2]});
            chk($sformatf("v%0d mem_stall", i), {31'b0, mem_stall}, 32'h0);
            chk($sformatf("v%0d MEMID_rd_we", i), {31'b0, MEMID_rd_we}, {31'b0, vecs[i].v});
            if (vecs[i].st && vecs[i].e_req)
                chk($sformatf("v%0d mem_data_in", i), mem_data_in, vecs[i].e_din);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d MEMWB_valid", i), {31'b0, MEMWB_valid}, {31'b0, vecs[i].v});
            chk($sformatf("v%0d MEMWB_fault", i), {31'b0, MEMWB_fault}, {31'b0, vecs[i].e_fault});
            chk($sformatf("v%0d MEMWB_rd_we", i), {31'b0, MEMWB_rd_we},
                {31'b0, vecs[i].v & ~vecs[i].e_fault});
            chk($sformatf("v%0d MEMWB_rd_data", i), MEMWB_rd_data, vecs[i].addr);
            chk($sformatf("v%0d MEMWB_des_reg_num", i), {28'b0, MEMWB_des_reg_num}, 32'd5);
            if (vecs[i].ld && !vecs[i].e_fault)
                chk($sformatf("v%0d MEMWB_data_read", i), MEMWB_data_read_from_mem, vecs[i].e_rdata);
        end

        // Slow memory: ready after three wait cycles.
        drive(1, 32'h200, 32'h0, 1, 0, 2'b10, 0, 32'hCAFEF00D, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("slow stall c%0d", c), {31'b0, mem_stall}, 32'h1);
            chk($sformatf("slow req c%0d", c), {31'b0, mem_req}, 32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("slow bubble valid c%0d", c), {31'b0, MEMWB_valid}, 32'h0);
            chk($sformatf("slow bubble rd_we c%0d", c), {31'b0, MEMWB_rd_we}, 32'h0);
        end
        mem_ready = 1'b1;
        #1;
        chk("slow ready stall", {31'b0, mem_stall}, 32'h0);
        @(posedge clk);
        #1;
        chk("slow valid", {31'b0, MEMWB_valid}, 32'h1);
        chk("slow fault", {31'b0, MEMWB_fault}, 32'h0);
        chk("slow data", MEMWB_data_read_from_mem, 32'hCAFEF00D);
        chk("slow rd_we", {31'b0, MEMWB_rd_we}, 32'h1);

        // Timeout: ready never arrives.
        drive(1, 32'h300, 32'h55AA55AA, 0, 1, 2'b10, 0, 32'h0, 0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("tmo stall c%0d", c), {31'b0, mem_stall}, 32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("tmo bubble c%0d", c), {31'b0, MEMWB_valid}, 32'h0);
        end
        #1;
        chk("tmo abort stall", {31'b0, mem_stall}, 32'h0);
        chk("tmo abort req", {31'b0, mem_req}, 32'h1);
        @(posedge clk);
        #1;
        chk("tmo valid", {31'b0, MEMWB_valid}, 32'h1);
        chk("tmo fault", {31'b0, MEMWB_fault}, 32'h1);
        chk("tmo rd_we", {31'b0, MEMWB_rd_we}, 32'h0);
        // Back in IDLE, the still-pending access starts a fresh wait and stalls again.
        #1;
        chk("tmo idle restart stall", {31'b0, mem_stall}, 32'h1);
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;

        // Ready arrives on the same cycle the counter hits its limit.
        drive(1, 32'h104, 32'h0, 1, 0, 2'b10, 0, 32'h0BADF00D, 0);
        repeat (4) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        #1;
        chk("race stall", {31'b0, mem_stall}, 32'h0);
        @(posedge clk);
        #1;
        chk("race valid", {31'b0, MEMWB_valid}, 32'h1);
        chk("race fault", {31'b0, MEMWB_fault}, 32'h0);
        chk("race data", MEMWB_data_read_from_mem, 32'h0BADF00D);

        // Reset while waiting.
        drive(1, 32'h108, 32'h0, 1, 0, 2'b10, 0, 32'h12345678, 0);
        #1;
        chk("rstwait stall", {31'b0, mem_stall}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("rstwait mem_req", {31'b0, mem_req}, 32'h0);
        chk("rstwait valid", {31'b0, MEMWB_valid}, 32'h0);
        chk("rstwait fault", {31'b0, MEMWB_fault}, 32'h0);
        chk("rstwait rd_we", {31'b0, MEMWB_rd_we}, 32'h0);
        chk("rstwait rd_data", MEMWB_rd_data, 32'h0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
